// File: rtl/if_spi_slave.sv
// SPI responder (CPHA=0, MSB first) oversampling the pins on clk; received bytes become
// visible to the host only after the frame ends, bytes written by the host are returned on miso.
module if_spi_slave #(
  parameter int CPOL       = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       n_cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] in_data,
  input  logic       in_ena,
  output logic [7:0] out_data,
  output logic       have_msg,
  output logic [7:0] len,
  input  logic       enc_rdreq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic CPOL_BIT = (CPOL != 0);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // n_cs syncs reset low so a frame already in progress at reset release is never joined.
  localparam logic [2:0] SYNC_RST = {1'b0, CPOL_BIT, 1'b0};

  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, BYTE_DONE} state_t;

  logic [2:0] pin_raw;
  logic [2:0] pin_sync;
  assign pin_raw = {n_cs, sclk, mosi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg, s2_reg;
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          s1_reg <= SYNC_RST[gi];
          s2_reg <= SYNC_RST[gi];
        end else begin
          s1_reg <= pin_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign pin_sync[gi] = s2_reg;
    end
  endgenerate

  logic cs_s, sclk_s, mosi_s;
  assign cs_s   = pin_sync[2];
  assign sclk_s = pin_sync[1];
  assign mosi_s = pin_sync[0];

  logic cs_prev_reg, sclk_prev_reg;
  logic lead_reg, trail_reg, cs_fall_reg, cs_rise_reg, mosi_d_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cs_prev_reg   <= 1'b0;
      sclk_prev_reg <= CPOL_BIT;
      lead_reg      <= 1'b0;
      trail_reg     <= 1'b0;
      cs_fall_reg   <= 1'b0;
      cs_rise_reg   <= 1'b0;
      mosi_d_reg    <= 1'b0;
    end else begin
      cs_prev_reg   <= cs_s;
      sclk_prev_reg <= sclk_s;
      lead_reg      <= (sclk_s != sclk_prev_reg) && (sclk_s != CPOL_BIT) && !cs_s;
      trail_reg     <= (sclk_s != sclk_prev_reg) && (sclk_s == CPOL_BIT) && !cs_s;
      cs_fall_reg   <= cs_prev_reg && !cs_s;
      cs_rise_reg   <= !cs_prev_reg && cs_s;
      mosi_d_reg    <= mosi_s;
    end
  end

  state_t state_reg, state_next;
  logic [7:0]    tx_shift_reg, rx_shift_reg;
  logic [2:0]    bit_cnt_reg;
  logic [CW-1:0] frame_cnt_reg, committed_reg;
  logic          tx_load, tx_shift_en, rx_sample;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (cs_fall_reg) state_next = SELECT;
      SELECT:    state_next = cs_rise_reg ? IDLE : SHIFT;
      SHIFT: begin
        if (cs_rise_reg)                          state_next = IDLE;
        else if (lead_reg && bit_cnt_reg == 3'd7) state_next = BYTE_DONE;
      end
      BYTE_DONE: begin
        if (cs_rise_reg)    state_next = IDLE;
        else if (trail_reg) state_next = SHIFT;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    rx_sample   = 1'b0;
    miso        = 1'b0;
    case (state_reg)
      SELECT:    tx_load = !cs_rise_reg;
      SHIFT: begin
        rx_sample   = lead_reg && !cs_rise_reg;
        tx_shift_en = trail_reg && !cs_rise_reg;
        miso        = tx_shift_reg[7];
      end
      BYTE_DONE: begin
        tx_load = trail_reg && !cs_rise_reg;
        miso    = tx_shift_reg[7];
      end
      default: ;
    endcase
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_reg, tx_rd_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic          tx_push, tx_pop;

  assign tx_push = in_ena && (tx_cnt_reg != DEPTH_C);
  assign tx_pop  = tx_load && (tx_cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_reg] <= in_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_wr_reg  <= '0;
      tx_rd_reg  <= '0;
      tx_cnt_reg <= '0;
    end else begin
      if (tx_push) tx_wr_reg <= tx_wr_reg + AW'(1);
      if (tx_pop)  tx_rd_reg <= tx_rd_reg + AW'(1);
      tx_cnt_reg <= tx_cnt_reg + (tx_push ? CW'(1) : '0) - (tx_pop ? CW'(1) : '0);
    end
  end

  // RX FIFO; bytes of the current frame sit beyond the committed region until n_cs rises
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_reg, rx_rd_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [7:0]    rx_byte;
  logic          rx_push, rd_accept, frame_end;

  assign rx_byte   = {rx_shift_reg[6:0], mosi_d_reg};
  assign rx_push   = rx_sample && (bit_cnt_reg == 3'd7) && (rx_cnt_reg != DEPTH_C);
  assign rd_accept = enc_rdreq && (committed_reg != '0);
  assign frame_end = (state_reg != IDLE) && cs_rise_reg;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_reg] <= rx_byte;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_wr_reg  <= '0;
      rx_rd_reg  <= '0;
      rx_cnt_reg <= '0;
    end else begin
      if (rx_push)   rx_wr_reg <= rx_wr_reg + AW'(1);
      if (rd_accept) rx_rd_reg <= rx_rd_reg + AW'(1);
      rx_cnt_reg <= rx_cnt_reg + (rx_push ? CW'(1) : '0) - (rd_accept ? CW'(1) : '0);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      bit_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      committed_reg <= '0;
    end else begin
      if (state_reg == SELECT) begin
        bit_cnt_reg   <= '0;
        frame_cnt_reg <= '0;
        rx_shift_reg  <= '0;
      end
      if (tx_load)          tx_shift_reg <= tx_pop ? tx_mem[tx_rd_reg] : 8'h00;
      else if (tx_shift_en) tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      if (rx_sample) begin
        rx_shift_reg <= rx_byte;
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
      end
      if (rx_push) frame_cnt_reg <= frame_cnt_reg + CW'(1);
      committed_reg <= committed_reg + (frame_end ? frame_cnt_reg : '0)
                       - (rd_accept ? CW'(1) : '0);
    end
  end

  logic [8:0] committed_ext;
  assign committed_ext = 9'(committed_reg);
  assign have_msg = (committed_reg != '0);
  assign len      = (committed_ext > 9'd255) ? 8'hFF : committed_ext[7:0];
  assign out_data = have_msg ? rx_mem[rx_rd_reg] : 8'h00;

endmodule

// File: tb/tb_if_spi_slave.sv
// Directed bench for if_spi_slave: three instances (CPOL=0, CPOL=1, FIFO_DEPTH=4) share the
// SPI pins; host strobes go only to the instance under test, each test starts from reset.
module tb_if_spi_slave;
  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       n_cs = 1'b1;
  logic       sclk_base = 1'b0;
  logic       sclk_inv;
  logic       mosi = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ena = 1'b0;
  logic       enc_rdreq = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [2:0] ena_v, rdreq_v, miso_v, have_v;
  logic [7:0] out0, out1, out2, len0, len1, len2;
  logic       miso_s, have_s;
  logic [7:0] out_s, len_s;
  int         passed = 0;
  int         total = 0;

  assign sclk_inv = ~sclk_base;
  assign ena_v    = {in_ena && sel == 2'd2, in_ena && sel == 2'd1, in_ena && sel == 2'd0};
  assign rdreq_v  = {enc_rdreq && sel == 2'd2, enc_rdreq && sel == 2'd1, enc_rdreq && sel == 2'd0};

  always #5 clk = ~clk;

  if_spi_slave #(.CPOL(0), .FIFO_DEPTH(16)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .n_cs(n_cs), .sclk(sclk_base), .mosi(mosi), .miso(miso_v[0]),
    .in_data(in_data), .in_ena(ena_v[0]), .out_data(out0), .have_msg(have_v[0]), .len(len0),
    .enc_rdreq(rdreq_v[0]));
  if_spi_slave #(.CPOL(1), .FIFO_DEPTH(16)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .n_cs(n_cs), .sclk(sclk_inv), .mosi(mosi), .miso(miso_v[1]),
    .in_data(in_data), .in_ena(ena_v[1]), .out_data(out1), .have_msg(have_v[1]), .len(len1),
    .enc_rdreq(rdreq_v[1]));
  if_spi_slave #(.CPOL(0), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .n_cs(n_cs), .sclk(sclk_base), .mosi(mosi), .miso(miso_v[2]),
    .in_data(in_data), .in_ena(ena_v[2]), .out_data(out2), .have_msg(have_v[2]), .len(len2),
    .enc_rdreq(rdreq_v[2]));

  always_comb begin
    miso_s = miso_v[0]; have_s = have_v[0]; out_s = out0; len_s = len0;
    case (sel)
      2'd1: begin miso_s = miso_v[1]; have_s = have_v[1]; out_s = out1; len_s = len1; end
      2'd2: begin miso_s = miso_v[2]; have_s = have_v[2]; out_s = out2; len_s = len2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else begin
      passed++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic do_reset();
    n_cs = 1'b1; sclk_base = 1'b0; in_ena = 1'b0; enc_rdreq = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk); in_data = b; in_ena = 1'b1;
    @(negedge clk); in_ena = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge clk); enc_rdreq = 1'b1;
    @(negedge clk); enc_rdreq = 1'b0;
  endtask

  task automatic cs_low();
    n_cs = 1'b0; #100;
  endtask

  task automatic cs_high();
    #HALF; n_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // master side: miso is captured just before each leading edge
  task automatic xfer_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = d[i];
      #HALF; r[i] = miso_s;
      sclk_base = 1'b1;
      #HALF; sclk_base = 1'b0;
    end
  endtask

  task automatic loopback(input logic [1:0] s);
    logic [7:0] r;
    sel = s; do_reset();
    push_tx(8'hA5); push_tx(8'h3C);
    cs_low();
    xfer_bits(8'h12, 8, r); check("lb miso0", r, 8'hA5);
    xfer_bits(8'h34, 8, r); check("lb miso1", r, 8'h3C);
    check("lb hidden", have_s, 1'b0);
    cs_high();
    check("lb have", have_s, 1'b1);
    check("lb len", len_s, 8'd2);
    check("lb out0", out_s, 8'h12);
    pop_rx();
    check("lb out1", out_s, 8'h34);
    check("lb len1", len_s, 8'd1);
    pop_rx();
    check("lb empty", have_s, 1'b0);
    check("lb out0x", out_s, 8'h00);
  endtask

  initial begin
    logic [7:0] r;
    do_reset();
    check("rst miso", miso_s, 1'b0);
    check("rst out", out_s, 8'h00);
    check("rst have", have_v, 3'b000);
    check("rst len", len_s, 8'd0);

    loopback(2'd0);

    // TX empty
    sel = 2'd0; do_reset();
    cs_low();
    for (int i = 0; i < 3; i++) begin
      xfer_bits(8'(i + 1), 8, r); check("txe miso", r, 8'h00);
    end
    cs_high();
    check("txe len", len_s, 8'd3);
    check("txe out", out_s, 8'h01);

    // partial byte
    do_reset();
    cs_low();
    xfer_bits(8'hC3, 8, r);
    xfer_bits(8'hF0, 4, r);
    cs_high();
    check("part len", len_s, 8'd1);
    check("part out", out_s, 8'hC3);
    pop_rx();
    check("part empty", have_s, 1'b0);

    // overflow on the 4-deep instance
    sel = 2'd2; do_reset();
    for (int i = 0; i < 5; i++) push_tx(8'(8'h10 + i));
    cs_low();
    for (int i = 0; i < 6; i++) begin
      xfer_bits(8'(8'h61 + i), 8, r);
      check("ovf miso", r, (i < 4) ? 8'(8'h10 + i) : 8'h00);
    end
    cs_high();
    check("ovf len", len_s, 8'd4);
    for (int i = 0; i < 4; i++) begin
      check("ovf data", out_s, 8'(8'h61 + i));
      pop_rx();
    end
    check("ovf empty", have_s, 1'b0);

    // concurrency: reads during a frame and on the commit cycle
    sel = 2'd0; do_reset();
    cs_low();
    xfer_bits(8'hA1, 8, r); xfer_bits(8'hA2, 8, r);
    cs_high();
    check("cc len2", len_s, 8'd2);
    cs_low();
    xfer_bits(8'hB1, 8, r);
    check("cc head", out_s, 8'hA1);
    pop_rx();
    check("cc len1", len_s, 8'd1);
    xfer_bits(8'hB2, 8, r);
    #HALF;
    @(negedge clk); n_cs = 1'b1;
    repeat (3) @(negedge clk);
    check("cc pre", out_s, 8'hA2);
    enc_rdreq = 1'b1;
    @(negedge clk); enc_rdreq = 1'b0;
    repeat (6) @(negedge clk);
    check("cc net len", len_s, 8'd2);
    check("cc b1", out_s, 8'hB1);
    pop_rx();
    check("cc b2", out_s, 8'hB2);
    pop_rx();
    check("cc done", have_s, 1'b0);

    // CPOL=1 loopback, then reset mid-byte
    loopback(2'd1);
    push_tx(8'h77); push_tx(8'h88);
    cs_low();
    xfer_bits(8'h99, 4, r);
    @(negedge clk); n_rst = 1'b0;
    @(negedge clk);
    check("mrst miso", miso_s, 1'b0);
    check("mrst have", have_s, 1'b0);
    check("mrst len", len_s, 8'd0);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    xfer_bits(8'hFF, 4, r);
    cs_high();
    check("mrst ignored", have_s, 1'b0);
    cs_low();
    xfer_bits(8'h5A, 8, r);
    check("mrst miso0", r, 8'h00);
    cs_high();
    check("mrst len1", len_s, 8'd1);
    check("mrst data", out_s, 8'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
